// File: rtl/trivium_result_packer.sv
// Result packer downstream of the Trivium wrapper: measures the start-to-first-block
// latency, captures N_BLOCKS blocks and streams {latency, blocks} out as bytes.
module trivium_result_packer #(
  parameter int DATA_WIDTH     = 64,
  parameter int N_BLOCKS       = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  end_uut_i,
  input  logic [DATA_WIDTH-1:0] block_i,
  output logic [7:0]            out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int REC_BYTES = CNT_WIDTH / 8 + N_BLOCKS * DATA_WIDTH / 8;
  localparam int REC_W     = REC_BYTES * 8;
  localparam int IDX_W     = $clog2(N_BLOCKS + 1);
  localparam int BYTE_W    = $clog2(REC_BYTES + 1);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  end_prev_q, end_prev_d;
  logic [CNT_WIDTH-1:0]  lat_q, lat_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [IDX_W-1:0]      blk_idx_q, blk_idx_d;
  logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] buf_q [N_BLOCKS];
  logic [DATA_WIDTH-1:0] buf_d [N_BLOCKS];
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  blk_evt_s;
  logic [REC_W-1:0]      rec_s;

  // Byte idx of the record, counted from the most significant end.
  function automatic logic [7:0] byte_at(input logic [REC_W-1:0] rec, input logic [BYTE_W-1:0] idx);
    logic [REC_W-1:0] sh;
    sh = rec << {idx, 3'b000};
    return sh[REC_W-1 -: 8];
  endfunction

  // Flatten latency and buffer into the outgoing record, buffer[0] first.
  always_comb begin
    rec_s = {REC_W{1'b0}};
    rec_s[REC_W-1 -: CNT_WIDTH] = lat_q;
    for (int b = 0; b < N_BLOCKS; b++) begin
      rec_s[REC_W-1-CNT_WIDTH-b*DATA_WIDTH -: DATA_WIDTH] = buf_q[b];
    end
  end

  // Next-state logic for the capture/drain controller.
  always_comb begin
    state_d     = state_q;
    end_prev_d  = end_uut_i;
    lat_d       = lat_q;
    tmo_d       = tmo_q;
    blk_idx_d   = blk_idx_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    blk_evt_s   = end_uut_i & ~end_prev_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          end_prev_d = 1'b0;
          lat_d      = {CNT_WIDTH{1'b0}};
          tmo_d      = {TMO_W{1'b0}};
          blk_idx_d  = {IDX_W{1'b0}};
          timeout_d  = 1'b0;
          for (int b = 0; b < N_BLOCKS; b++) begin
            buf_d[b] = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (blk_idx_q == IDX_W'(N_BLOCKS)) begin
          state_d     = S_DRAIN;
          byte_idx_d  = {BYTE_W{1'b0}};
          out_valid_d = 1'b1;
          out_data_d  = byte_at(rec_s, {BYTE_W{1'b0}});
        end else begin
          // Latency keeps counting up to and including the first block cycle.
          if (blk_idx_q == {IDX_W{1'b0}} && lat_q != {CNT_WIDTH{1'b1}}) begin
            lat_d = lat_q + CNT_WIDTH'(1);
          end else begin
            lat_d = lat_q;
          end
          if (blk_evt_s) begin
            for (int b = 0; b < N_BLOCKS; b++) begin
              if (blk_idx_q == IDX_W'(b)) begin
                buf_d[b] = block_i;
              end else begin
                buf_d[b] = buf_q[b];
              end
            end
            blk_idx_d = blk_idx_q + IDX_W'(1);
            tmo_d     = {TMO_W{1'b0}};
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Freeze latency here so byte 0 matches the record drained later.
            lat_d       = lat_q;
            timeout_d   = 1'b1;
            state_d     = S_DRAIN;
            byte_idx_d  = {BYTE_W{1'b0}};
            out_valid_d = 1'b1;
            out_data_d  = byte_at(rec_s, {BYTE_W{1'b0}});
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_ready_i) begin
          if (byte_idx_q == BYTE_W'(REC_BYTES - 1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            out_data_d = byte_at(rec_s, byte_idx_q + BYTE_W'(1));
          end
        end else begin
          out_data_d = out_data_q;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      end_prev_q  <= 1'b0;
      lat_q       <= {CNT_WIDTH{1'b0}};
      tmo_q       <= {TMO_W{1'b0}};
      blk_idx_q   <= {IDX_W{1'b0}};
      byte_idx_q  <= {BYTE_W{1'b0}};
      for (int b = 0; b < N_BLOCKS; b++) begin
        buf_q[b] <= {DATA_WIDTH{1'b0}};
      end
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      end_prev_q  <= end_prev_d;
      lat_q       <= lat_d;
      tmo_q       <= tmo_d;
      blk_idx_q   <= blk_idx_d;
      byte_idx_q  <= byte_idx_d;
      for (int b = 0; b < N_BLOCKS; b++) begin
        buf_q[b] <= buf_d[b];
      end
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: doc/trivium_result_packer.md
Name: trivium_result_packer

Overview:
Sits directly downstream of the Trivium wrapper in the hardware-verification top. It consumes the wrapper's end/block outputs and measures latency from the UUT run start to the first block. It captures N_BLOCKS keystream blocks and serialises a fixed-length record (latency count followed by the blocks) as a byte stream. The autotest SD writer drains that stream into its sector buffer.

Parameters:
DATA_WIDTH, 64, width of one keystream block from the wrapper; must be a multiple of 8.
N_BLOCKS, 4, blocks captured per record.
CNT_WIDTH, 32, latency counter width; must be a multiple of 8.
TIMEOUT_CYCLES, 1048576, cycles without a new block before the run is aborted.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
start_i  in  1  one-cycle pulse; the UUT reset has just been released and a run begins.
end_uut_i  in  1  wrapper end flag; a rising edge marks a new valid block.
block_i  in  DATA_WIDTH  wrapper output block; sampled on the cycle a rising edge of end_uut_i is detected.
out_data_o  out  8  record byte.
out_valid_o  out  1  out_data_o is valid.
out_ready_i  in  1  consumer accepts the byte when out_valid_o and out_ready_i are both high.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse after the last record byte transfers.
timeout_o  out  1  sticky; set on timeout, cleared by the next accepted start_i or by reset.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - out_data_o = 0, out_valid_o = 0, busy_o = 0, done_o = 0, timeout_o = 0.
  - Latency counter, timeout counter, block index, byte index, buffer and end_uut_i edge register all clear.
  - Reset asserted mid-operation abandons the record; no partial bytes are emitted after release.
- Edge detect: end_prev registers end_uut_i. blk_evt = end_uut_i & ~end_prev. end_prev is cleared on start_i.
- IDLE:
  - start_i moves to RUN.
  - Entering RUN clears the latency counter, timeout counter, block index and buffer, and clears timeout_o.
  - blk_evt in IDLE is ignored.
- RUN:
  - Latency counter increments every cycle until the first blk_evt, then freezes.
  - The counter saturates at all-ones and does not wrap.
  - Counting convention: blk_evt on the first cycle after start_i gives latency 1.
  - On each blk_evt, block_i is stored at buffer[block index], the block index increments and the timeout counter clears.
  - Otherwise the timeout counter increments.
  - Block index reaching N_BLOCKS moves to DRAIN on the next cycle.
  - Timeout counter reaching TIMEOUT_CYCLES-1 sets timeout_o and moves to DRAIN; unfilled slots stay 0.
  - If a timeout and a blk_evt occur in the same cycle, the block is stored and no timeout is flagged.
  - start_i while busy is ignored, in every non-IDLE state.
- DRAIN:
  - Record length L = CNT_WIDTH/8 + N_BLOCKS*DATA_WIDTH/8, which is 36 bytes by default.
  - Byte order: latency counter MSB first, then buffer[0] through buffer[N_BLOCKS-1], each MSB first.
  - out_valid_o rises on the first DRAIN cycle.
  - out_data_o stays stable while out_valid_o is high and out_ready_i is low.
  - The byte index advances only on a transfer. Back-to-back transfers run at 1 byte/cycle.
  - blk_evt in DRAIN is ignored.
  - After byte L-1 transfers, out_valid_o drops in the next cycle, done_o pulses in that same cycle, and the state goes to IDLE.
- All outputs are registered.
- Minimum start_i-to-first-byte latency is N_BLOCKS block events plus 2 cycles.

Test Plan:
1. Reset, then start_i, then blk_evt at 10 cycles after start with block 0x0123456789ABCDEF, then 3 more blocks at intervals of 64 cycles; out_ready_i held at 1 -> 36 consecutive bytes. First 4 bytes are 00 00 00 0A; bytes 4..11 are 01 23 45 67 89 AB CD EF. done_o pulses once; timeout_o = 0.
2. Same run as scenario 1 with out_ready_i toggling pseudo-randomly -> identical byte sequence. out_data_o stays stable whenever valid is high and ready is low; no byte is lost or duplicated.
3. TIMEOUT_CYCLES = 100, only 2 blocks delivered -> timeout_o = 1 and 36 bytes emitted. Bytes 20..35 are all 0x00.
4. end_uut_i held high for 50 cycles, then low, then high again -> exactly 2 blocks captured, one per rising edge. start_i pulsed during DRAIN is ignored; the record is unchanged.
5. rst asserted at byte 17 of DRAIN, then released and a new run started -> out_valid_o is 0 immediately on reset. The new record starts at byte 0 with a fresh latency count.
6. CNT_WIDTH = 8 with first block arriving 300 cycles after start -> latency byte = 0xFF (saturated).
